// File: rtl/sa_req_arbiter.sv
// sa_req_arbiter: round-robin front end that shares a single SA search engine
// among NREQ requesters. It launches one run at a time, holds the target
// stable for the whole run, and returns x/y tagged with the owning requester.
//
// Optional feature: define SA_ARB_WATCHDOG_EN to abort a run whose sa_done
// has not arrived TIMEOUT cycles after the launch. The abort returns an
// error response. Without the macro, rsp_err is tied low and WAIT holds
// until sa_done arrives.
module sa_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TW      = 10,
    parameter int XW      = 8,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*TW-1:0]  req_target,
    output logic [NREQ-1:0]     ack,
    output logic                busy,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [XW-1:0]       rsp_x,
    output logic [TW-1:0]       rsp_y,
    output logic                rsp_err,
    output logic [TW-1:0]       sa_target,
    output logic                sa_start,
    input  logic                sa_done,
    input  logic [XW-1:0]       sa_x,
    input  logic [TW-1:0]       sa_y
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] owner;

    // Requests rotated so that bit 0 is the requester the pointer points at.
    logic [NREQ-1:0] req_rot;
    logic            win_found;
    int              win_off;
    int              win_sum;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  rr_next;
    logic [TW-1:0]   win_target;

    assign req_rot = NREQ'({req, req} >> rr_ptr);

`ifdef SA_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    logic [WDW-1:0] wd_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    // Pick the first requester at or after rr_ptr, wrapping, plus its target.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave it
        // unassigned and infer a latch.
        win_found  = 1'b0;
        win_off    = 0;
        win_target = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_off   = k;
            end
        end
        win_sum = int'(rr_ptr) + win_off;
        if (win_sum >= NREQ) begin
            win_sum = win_sum - NREQ;
        end
        win_id  = IDW'(win_sum);
        rr_next = (win_sum == NREQ - 1) ? '0 : IDW'(win_sum + 1);
        for (int k = 0; k < NREQ; k++) begin
            if (k == win_sum) begin
                win_target = req_target[k*TW +: TW];
            end
        end
    end

    // Grant / run / drain sequencer. All outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state uses non-blocking assignments so that every register
        // samples the values from before the clock edge.
        if (!reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_x     <= '0;
            rsp_y     <= '0;
            sa_target <= '0;
            sa_start  <= 1'b0;
`ifdef SA_ARB_WATCHDOG_EN
            rsp_err   <= 1'b0;
            wd_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // sa_done is ignored here. DRAIN has already waited for
                    // it to fall.
                    if (win_found) begin
                        sa_target <= win_target;
                        owner     <= win_id;
                        ack       <= NREQ'(1) << win_id;
                        sa_start  <= 1'b1;
                        busy      <= 1'b1;
                        rr_ptr    <= rr_next;
                        state     <= S_WAIT;
`ifdef SA_ARB_WATCHDOG_EN
                        wd_cnt    <= '0;
`endif
                    end
                end

                S_WAIT: begin
                    sa_start <= 1'b0;
                    ack      <= '0;
                    if (sa_done) begin
                        rsp_valid <= 1'b1;
                        rsp_x     <= sa_x;
                        rsp_y     <= sa_y;
                        rsp_id    <= owner;
                        state     <= S_DRAIN;
`ifdef SA_ARB_WATCHDOG_EN
                        rsp_err   <= 1'b0;
                    end else if (wd_cnt == WD_LAST) begin
                        // The SA never finished. Return an error response for
                        // the owner and let DRAIN absorb any late done.
                        rsp_valid <= 1'b1;
                        rsp_x     <= '0;
                        rsp_y     <= '0;
                        rsp_id    <= owner;
                        rsp_err   <= 1'b1;
                        state     <= S_DRAIN;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end

                S_DRAIN: begin
                    // The next start cannot be issued while the previous
                    // done is still high.
                    rsp_valid <= 1'b0;
                    if (!sa_done) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_req_arbiter.sv
// tb_sa_req_arbiter: table-driven bench with a round-robin reference model and
// a response scoreboard. A behavioural SA stub raises done for 2 cycles, 6
// cycles after each start, and returns x = target[9:2] and y = target.
module tb_sa_req_arbiter;

    localparam int NREQ    = 4;
    localparam int TW      = 10;
    localparam int XW      = 8;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*TW-1:0]  req_target;
    logic [NREQ-1:0]     ack;
    logic                busy;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [XW-1:0]       rsp_x;
    logic [TW-1:0]       rsp_y;
    logic                rsp_err;
    logic [TW-1:0]       sa_target;
    logic                sa_start;
    logic                sa_done;
    logic [XW-1:0]       sa_x;
    logic [TW-1:0]       sa_y;

    sa_req_arbiter #(
        .NREQ(NREQ), .TW(TW), .XW(XW), .IDW(IDW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_target(req_target),
        .ack(ack), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err),
        .sa_target(sa_target), .sa_start(sa_start), .sa_done(sa_done),
        .sa_x(sa_x), .sa_y(sa_y)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [XW-1:0]  x;
        logic [TW-1:0]  y;
        logic           err;
    } rsp_t;

    typedef struct {
        string           name;
        logic [NREQ-1:0] req_mask;
        logic [NREQ*TW-1:0] tgts;
        int              first;
        int              runs;
    } vec_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- SA stub ----------------
    int              stub_lat  = 0;
    int              stub_hold = 0;
    logic [TW-1:0]   stub_tgt  = '0;
    bit              stub_en   = 1'b1;

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            stub_lat  = 0;
            stub_hold = 0;
            sa_done   = 1'b0;
        end else if (sa_start) begin
            stub_tgt = sa_target;
            stub_lat = LAT;
        end else if (stub_lat > 0) begin
            stub_lat--;
            if (stub_lat == 0 && stub_en) begin
                sa_done   = 1'b1;
                sa_x      = stub_tgt[TW-1:2];
                sa_y      = stub_tgt;
                stub_hold = 2;
            end
        end else if (stub_hold > 0) begin
            stub_hold--;
            if (stub_hold == 0) sa_done = 1'b0;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [NREQ-1:0]    req_smp;
    logic [NREQ*TW-1:0] tgt_smp;
    int                 m_ptr = 0;
    int                 m_w;
    logic [TW-1:0]      cur_tgt = '0;
    logic [TW-1:0]      exp_y;
    logic               done_prev = 1'b0;
    logic               start_prev = 1'b0;
    bit                 rsp_pending = 1'b0;
    int                 n_rsp = 0;
    int                 n_grants[NREQ];
    rsp_t               exp_rsp;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        req_smp = req;
        tgt_smp = req_target;
    end

    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            m_ptr       = 0;
            rsp_pending = 1'b0;
            done_prev   = 1'b0;
            start_prev  = 1'b0;
        end else begin
            if (ack != '0) begin
                m_w = rr_pick(req_smp, m_ptr);
                if (m_w < 0) begin
                    check("grant_without_req", ack, 0);
                end else begin
                    exp_y = tgt_smp[m_w*TW +: TW];
                    check("grant_onehot", ack, 64'(1) << m_w);
                    check("start_with_ack", sa_start, 1);
                    check("target_latched", sa_target, exp_y);
                    check("busy_on_grant", busy, 1);
                    check("no_start_while_done", done_prev, 0);
                    if (stub_en) exp_rsp = '{id: IDW'(m_w), x: exp_y[TW-1:2], y: exp_y, err: 1'b0};
                    else         exp_rsp = '{id: IDW'(m_w), x: '0, y: '0, err: 1'b1};
                    sb.push_back(exp_rsp);
                    cur_tgt = exp_y;
                    m_ptr   = (m_w + 1) % NREQ;
                    n_grants[m_w]++;
                end
            end else if (sa_start) begin
                check("start_without_ack", sa_start, 0);
            end
            if (sa_start) check("start_one_cycle", start_prev, 0);
            if (busy && ack == '0) check("target_hold", sa_target, cur_tgt);
            if (rsp_pending) begin
                check("rsp_latency", rsp_valid, 1);
                rsp_pending = 1'b0;
            end
            if (rsp_valid) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", rsp_valid, 0);
                end else begin
                    exp_rsp = sb.pop_front();
                    check($sformatf("rsp id=%0d", exp_rsp.id),
                          {rsp_id, rsp_x, rsp_y, rsp_err}, exp_rsp);
                end
            end
            if (sa_done && !done_prev && busy && sb.size() != 0) rsp_pending = 1'b1;
            done_prev  = sa_done;
            start_prev = sa_start;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_idle();
        int cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while ((busy || sb.size() != 0) && cyc < 500);
        check("idle_reached", (busy || sb.size() != 0), 0);
    endtask

    task automatic wait_ack(output logic [NREQ-1:0] a);
        int cyc = 0;
        a = '0;
        do begin
            @(posedge clk); #1; cyc++;
            a = ack;
        end while (a == '0 && cyc < 100);
        check("ack_wait", (a != '0), 1);
    endtask

    // Apply one table row. Each requester drops its req when acked.
    task automatic run_vec(input vec_t v);
        int cyc = 0;
        int got = 0;
        bit first = 1'b1;
        @(posedge clk); #1;
        req        = v.req_mask;
        req_target = v.tgts;
        while (got < v.runs && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
            if (ack != '0) begin
                if (first) begin
                    check({v.name, " first_grant"}, ack, 64'(1) << v.first);
                    check({v.name, " ack_latency"}, cyc, 1);
                    first = 1'b0;
                end
                req = req & ~ack;
                got++;
            end
        end
        check({v.name, " grant_count"}, got, v.runs);
        req = '0;
        wait_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t            tbl[7];
        vec_t            after_rst;
        logic [NREQ-1:0] a;
        int              cyc;
        int              rsp_before;
        int              n3;

        tbl[0] = '{"contention",   4'b1111, {10'd400, 10'd300, 10'd200, 10'd100}, 0, 4};
        tbl[1] = '{"rerequest",    4'b1111, {10'd404, 10'd303, 10'd202, 10'd101}, 0, 4};
        tbl[2] = '{"single_550",   4'b0001, {10'd0,   10'd0,   10'd0,   10'd550}, 0, 1};
        tbl[3] = '{"b2b_800",      4'b0001, {10'd0,   10'd0,   10'd0,   10'd800}, 0, 1};
        tbl[4] = '{"max_target",   4'b0100, {10'd0,   10'd1023, 10'd0,  10'd0},   2, 1};
        tbl[5] = '{"wrap_3_0",     4'b1001, {10'd5,   10'd0,   10'd0,   10'd0},   3, 2};
        tbl[6] = '{"single_1",     4'b0010, {10'd0,   10'd0,   10'd1000, 10'd0},  1, 1};
        after_rst = '{"after_reset", 4'b0100, {10'd0, 10'd300, 10'd0, 10'd0}, 2, 1};

        for (int i = 0; i < NREQ; i++) n_grants[i] = 0;
        reset      = 1'b0;
        req        = '0;
        req_target = '0;
        sa_done    = 1'b0;
        sa_x       = '0;
        sa_y       = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              {ack, busy, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err, sa_target, sa_start}, 0);
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // A request withdrawn before it is acked is never granted.
        n3 = n_grants[3];
        @(posedge clk); #1;
        req = 4'b0001; req_target[9:0] = 10'd42;
        wait_ack(a);
        req = 4'b1000; req_target[39:30] = 10'd9;
        repeat (3) begin @(posedge clk); #1; end
        req = '0;
        wait_idle();
        repeat (3) begin @(posedge clk); #1; end
        check("withdrawn_not_granted", n_grants[3], n3);

        // A request still high after ack is served again.
        @(posedge clk); #1;
        req = 4'b0010; req_target[19:10] = 10'd777;
        wait_ack(a);
        check("held_req_first", a, 4'b0010);
        wait_ack(a);
        check("held_req_regrant", a, 4'b0010);
        req = '0;
        wait_idle();

        // sa_done while IDLE is ignored.
        rsp_before = n_rsp;
        @(posedge clk); #2;
        sa_done = 1'b1; stub_hold = 2;
        repeat (6) begin @(posedge clk); #1; end
        check("idle_done_no_rsp", n_rsp, rsp_before);
        check("idle_done_not_busy", busy, 0);

        // Reset in the middle of a run drops it without a response.
        @(posedge clk); #1;
        req = 4'b0001; req_target[9:0] = 10'd123;
        wait_ack(a);
        req = '0;
        repeat (2) begin @(posedge clk); #1; end
        rsp_before = n_rsp;
        #2 reset = 1'b0;
        #1;
        check("reset_async_outputs",
              {ack, busy, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err, sa_target, sa_start}, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        check("no_rsp_after_reset", n_rsp, rsp_before);
        run_vec(after_rst);

`ifdef SA_ARB_WATCHDOG_EN
        // The stub never answers. The abort lands TIMEOUT cycles after the
        // grant, and a late done pulse is absorbed.
        stub_en    = 1'b0;
        rsp_before = n_rsp;
        @(posedge clk); #1;
        req = 4'b0001; req_target[9:0] = 10'd77;
        wait_ack(a);
        req = '0;
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
        check("wd_abort_cycles", cyc, TIMEOUT);
        check("wd_rsp_err", rsp_err, 1);
        #1;
        sa_done = 1'b1; stub_hold = 2;
        wait_idle();
        repeat (4) begin @(posedge clk); #1; end
        check("wd_single_rsp", n_rsp, rsp_before + 1);
        stub_en = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
